alu_op_driver: RTL and testbench

ALU_OP_DRIVER -- requirements
Module: alu_op_driver

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_settle_cnt.sv | 28 ++
 rtl/alu_op_driver.sv | 112 +++++++++++
 tb/tb_alu_op_driver.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand driver: MIPS ALU control codes,
// driver FSM state type and the op-legality check.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } drvState_t;

  function automatic logic opLegal(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: opLegal = 1'b1;
      default:                                       opLegal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_settle_cnt.sv
// Settle down-counter: loaded when an op is launched, counts down while the
// ALU settles, flags done on the last settle cycle.
module alu_settle_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] loadVal,
  input  logic             dec,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= loadVal;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign done = (count == CNT_W'(1));

endmodule

// File: rtl/alu_op_driver.sv
// Request/response wrapper that drives a combinational ALU and captures its
// result after a settle delay. Optional macro ALU_DRV_BYPASS_EN: back-to-back accept in RESP.
module alu_op_driver
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int WIDTH         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_r,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_r,
  output logic             rsp_zero,
  output logic             rsp_err
);

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

  drvState_t state;
  logic      reqFire;
  logic      reqLegal;
  logic      cntDone;

  always_comb begin
    req_ready = 1'b0;
    case (state)
      ST_IDLE: req_ready = 1'b1;
`ifdef ALU_DRV_BYPASS_EN
      // A new op may launch on the same edge the current response is taken.
      ST_RESP: req_ready = rsp_ready;
`else
      ST_RESP: req_ready = 1'b0;
`endif
      default: req_ready = 1'b0;
    endcase
  end

  assign reqFire  = req_valid && req_ready;
  assign reqLegal = opLegal(req_op);

  alu_settle_cnt #(
    .CNT_W(4)
  ) uSettleCnt (
    .clk     (clk),
    .rst     (rst),
    .load    (reqFire && reqLegal),
    .loadVal (SETTLE_LD),
    .dec     (state == ST_SETTLE),
    .done    (cntDone)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rsp_valid <= 1'b0;
      rsp_r     <= '0;
      rsp_zero  <= 1'b0;
      rsp_err   <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= OP_AND;
    end else begin
      case (state)
        ST_SETTLE: begin
          if (cntDone) begin
            rsp_r     <= alu_r;
            rsp_zero  <= (alu_r == '0);
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: ;
      endcase

      // An accepted request overrides the response hand-off above; illegal ops
      // leave the ALU ports untouched and answer immediately with an error.
      if (reqFire) begin
        if (reqLegal) begin
          alu_a     <= req_a;
          alu_b     <= req_b;
          alu_op    <= req_op;
          rsp_valid <= 1'b0;
          state     <= ST_SETTLE;
        end else begin
          rsp_r     <= '0;
          rsp_zero  <= 1'b0;
          rsp_err   <= 1'b1;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_op_driver.sv
// Scoreboard bench for alu_op_driver: two instances (settle 1 and settle 4)
// each driving a behavioural ALU; expectations come from a reference model.
module tb_alu_op_driver;

  localparam int W  = 32;
  localparam int SA = 1;
  localparam int SB = 4;
`ifdef ALU_DRV_BYPASS_EN
  localparam int GAP = SA + 1;
`else
  localparam int GAP = SA + 2;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // instance A
  logic         aRst = 1'b1, aReqValid = 1'b0, aReqReady, aRspValid, aRspReady = 1'b0;
  logic [3:0]   aReqOp = 4'd0, aAluOp;
  logic [W-1:0] aReqA = '0, aReqB = '0, aAluA, aAluB, aAluR, aRspR;
  logic         aRspZero, aRspErr;
  // instance B
  logic         bRst = 1'b1, bReqValid = 1'b0, bReqReady, bRspValid, bRspReady = 1'b1;
  logic [3:0]   bReqOp = 4'd0, bAluOp;
  logic [W-1:0] bReqA = '0, bReqB = '0, bAluA, bAluB, bAluR, bRspR;
  logic         bRspZero, bRspErr;

  alu_op_driver #(.SETTLE_CYCLES(SA), .WIDTH(W)) dutA (
    .clk(clk), .rst(aRst), .req_valid(aReqValid), .req_ready(aReqReady), .req_op(aReqOp),
    .req_a(aReqA), .req_b(aReqB), .alu_a(aAluA), .alu_b(aAluB), .alu_op(aAluOp), .alu_r(aAluR),
    .rsp_valid(aRspValid), .rsp_ready(aRspReady), .rsp_r(aRspR), .rsp_zero(aRspZero), .rsp_err(aRspErr));

  alu_op_driver #(.SETTLE_CYCLES(SB), .WIDTH(W)) dutB (
    .clk(clk), .rst(bRst), .req_valid(bReqValid), .req_ready(bReqReady), .req_op(bReqOp),
    .req_a(bReqA), .req_b(bReqB), .alu_a(bAluA), .alu_b(bAluB), .alu_op(bAluOp), .alu_r(bAluR),
    .rsp_valid(bRspValid), .rsp_ready(bRspReady), .rsp_r(bRspR), .rsp_zero(bRspZero), .rsp_err(bRspErr));

  // Behavioural MIPS ALU (combinational)
  function automatic logic [W-1:0] aluRef(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      4'b0000: aluRef = a & b;
      4'b0001: aluRef = a | b;
      4'b0010: aluRef = a + b;
      4'b0110: aluRef = a - b;
      4'b0111: aluRef = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      4'b1100: aluRef = ~(a | b);
      default: aluRef = '0;
    endcase
  endfunction

  function automatic bit isLegal(input logic [3:0] op);
    return (op == 4'd0) || (op == 4'd1) || (op == 4'd2) || (op == 4'd6) || (op == 4'd7) || (op == 4'd12);
  endfunction

  assign aAluR = aluRef(aAluOp, aAluA, aAluB);
  assign bAluR = aluRef(bAluOp, bAluA, bAluB);

  int passCnt = 0;
  int totCnt  = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    totCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [W-1:0] r;
    logic         zero;
    logic         err;
    int           issueCyc;
    int           lat;
    logic [W-1:0] xa;
    logic [W-1:0] xb;
    logic [3:0]   xop;
  } exp_t;

  exp_t         sbq[$];
  int           presQ[$];
  logic [W-1:0] lastA = '0, lastB = '0;
  logic [3:0]   lastOp = 4'd0;
  int           rspMode = 1;   // 0 random, 1 always ready, 2 held low
  bit           presented = 1'b0;

  initial forever begin
    @(negedge clk);
    case (rspMode)
      0:       aRspReady = ($urandom_range(0, 9) < 7);
      1:       aRspReady = 1'b1;
      default: aRspReady = 1'b0;
    endcase
  end

  // Monitor for instance A
  initial forever begin
    @(negedge clk);
    #3;
    if (aRst) begin
      presented = 1'b0;
    end else if (aRspValid) begin
      if (sbq.size() == 0) begin
        totCnt++;
        $display("FAIL unexpected_rsp: rsp_valid=1 with r=0x%0h, expected no response", aRspR);
      end else begin
        if (!presented) begin
          presented = 1'b1;
          presQ.push_back(cyc);
          check("latency", W'(cyc - sbq[0].issueCyc), W'(sbq[0].lat));
          check("alu_a", aAluA, sbq[0].xa);
          check("alu_b", aAluB, sbq[0].xb);
          check("alu_op", W'(aAluOp), W'(sbq[0].xop));
        end
        check("rsp_r", aRspR, sbq[0].r);
        check("rsp_zero", W'(aRspZero), W'(sbq[0].zero));
        check("rsp_err", W'(aRspErr), W'(sbq[0].err));
        if (aRspReady) begin
          void'(sbq.pop_front());
          presented = 1'b0;
        end
      end
    end
  end

  task automatic issueA(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    bit   got = 1'b0;
    @(negedge clk);
    aReqValid = 1'b1; aReqOp = op; aReqA = a; aReqB = b;
    for (int i = 0; i < 200 && !got; i++) begin
      #2;
      if (aReqReady) begin
        got = 1'b1;
        e.err      = !isLegal(op);
        e.r        = e.err ? '0 : aluRef(op, a, b);
        e.zero     = e.err ? 1'b0 : (e.r == '0);
        e.issueCyc = cyc;
        e.lat      = e.err ? 1 : SA + 1;
        if (!e.err) begin lastA = a; lastB = b; lastOp = op; end
        e.xa = lastA; e.xb = lastB; e.xop = lastOp;
        sbq.push_back(e);
        @(posedge clk);
      end else begin
        @(negedge clk);
      end
    end
    if (!got) begin
      totCnt++;
      $display("FAIL req_accept: request op=%0h never accepted, expected acceptance", op);
    end
  endtask

  task automatic idleA();
    @(negedge clk);
    aReqValid = 1'b0;
  endtask

  task automatic drainA();
    bit done = 1'b0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      #4;
      done = (sbq.size() == 0) && !aRspValid;
    end
    if (!done) begin
      totCnt++;
      $display("FAIL drain: %0d responses outstanding, expected 0", sbq.size());
    end
  endtask

  function automatic logic [3:0] pickOp(input bit wantLegal);
    logic [3:0] t[6] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};
    logic [3:0] o;
    if (wantLegal) return t[$urandom_range(0, 5)];
    o = 4'(($urandom_range(0, 15)));
    while (isLegal(o)) o = 4'(($urandom_range(0, 15)));
    return o;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int c0;
    int bad;
    bit seen;
    logic [W-1:0] ra, rb;

    // ---- instance A: reset values
    repeat (3) @(negedge clk);
    aRst = 1'b0;
    #3;
    check("rst_rsp_valid", W'(aRspValid), W'(0));
    check("rst_rsp_r", aRspR, '0);
    check("rst_rsp_zero", W'(aRspZero), W'(0));
    check("rst_rsp_err", W'(aRspErr), W'(0));
    check("rst_alu_a", aAluA, '0);
    check("rst_alu_b", aAluB, '0);
    check("rst_alu_op", W'(aAluOp), W'(0));
    check("rst_req_ready", W'(aReqReady), W'(1));

    // ---- directed ops
    rspMode = 1;
    issueA(4'b0010, 32'd5, 32'd7);                 idleA(); drainA();
    issueA(4'b1100, 32'hFFFF0000, 32'h0000FFFF);   idleA(); drainA();
    issueA(4'b0110, 32'd3, 32'd3);                 idleA(); drainA();
    issueA(4'b1111, 32'd77, 32'd88);               idleA(); drainA();

    // ---- SLT with response held off; a competing request must be ignored
    rspMode = 2;
    issueA(4'b0111, 32'hFFFFFFFF, 32'd1);
    @(negedge clk);
    aReqValid = 1'b1; aReqOp = 4'b0010; aReqA = 32'd9; aReqB = 32'd9;
    for (int i = 0; i < 12; i++) begin
      #3;
      check("held_req_ready", W'(aReqReady), W'(0));
      @(negedge clk);
    end
    #3;
    check("held_rsp_valid", W'(aRspValid), W'(1));
    @(negedge clk);
    aReqValid = 1'b0;
    rspMode = 1;
    drainA();

    // ---- randomized traffic with random back-pressure
    rspMode = 0;
    for (int n = 0; n < 80; n++) begin
      ra = $urandom();
      rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom());
      issueA(pickOp($urandom_range(0, 3) != 0), ra, rb);
      if ($urandom_range(0, 2) == 0) begin
        idleA();
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    idleA();
    rspMode = 1;
    drainA();

    // ---- throughput: three back-to-back ORs
    presQ.delete();
    issueA(4'b0001, 32'h0000_00F0, 32'h0000_000F);
    issueA(4'b0001, 32'h1234_0000, 32'h0000_5678);
    issueA(4'b0001, 32'd0, 32'd0);
    idleA();
    drainA();
    check("tput_count", W'(presQ.size()), W'(3));
    if (presQ.size() == 3) begin
      check("tput_gap1", W'(presQ[1] - presQ[0]), W'(GAP));
      check("tput_gap2", W'(presQ[2] - presQ[1]), W'(GAP));
    end

    // ---- instance B: latency with settle 4
    @(negedge clk);
    bRst = 1'b0;
    @(negedge clk);
    bReqValid = 1'b1; bReqOp = 4'b0010; bReqA = 32'd20; bReqB = 32'd22;
    #2;
    check("b_req_ready", W'(bReqReady), W'(1));
    c0 = cyc;
    @(negedge clk);
    bReqValid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      #3;
      if (bRspValid) seen = 1'b1;
      else @(negedge clk);
    end
    check("b_rsp_seen", W'(seen), W'(1));
    check("b_latency", W'(cyc - c0), W'(SB + 1));
    check("b_rsp_r", bRspR, 32'd42);

    // ---- instance B: reset during SETTLE aborts the transaction
    repeat (2) @(negedge clk);
    bReqValid = 1'b1; bReqOp = 4'b0010; bReqA = 32'd1; bReqB = 32'd2;
    @(negedge clk);
    bReqValid = 1'b0;
    @(negedge clk);
    bRst = 1'b1;
    @(negedge clk);
    bRst = 1'b0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      #3;
      if (bRspValid) bad++;
      @(negedge clk);
    end
    #3;
    check("abort_no_rsp", W'(bad), W'(0));
    check("abort_rsp_r", bRspR, '0);
    check("abort_rsp_zero", W'(bRspZero), W'(0));
    check("abort_rsp_err", W'(bRspErr), W'(0));
    check("abort_alu_a", bAluA, '0);
    check("abort_alu_b", bAluB, '0);
    check("abort_alu_op", W'(bAluOp), W'(0));
    check("abort_req_ready", W'(bReqReady), W'(1));

    $display("%0d/%0d checks passed", passCnt, totCnt);
    $finish;
  end

endmodule
